// File: rtl/vmem_pkg.sv
// Shared types and helpers for the vector load/store stage.
// Fixed geometry: 128-bit vectors moved as four 32-bit beats.
package vmem_pkg;

   localparam int VEC_BITS   = 128;
   localparam int WORD_BITS  = 32;
   localparam int BEATS      = VEC_BITS / WORD_BITS;
   localparam int BEAT_IDX_W = $clog2(BEATS);
   localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_STORE,
      S_LOAD_ISSUE,
      S_LOAD_DRAIN,
      S_WB,
      S_DONE,
      S_ERR
   } vmem_state_t;

   function automatic logic [WORD_BITS-1:0] beat_slice(input logic [VEC_BITS-1:0] vec,
                                                       input logic [BEAT_IDX_W-1:0] idx);
      return vec[int'(idx) * WORD_BITS +: WORD_BITS];
   endfunction

endpackage

// File: rtl/vec_beat_assembler.sv
// Purpose: collects 32-bit load beats into one vector register, one slot per capture.
// Latency: a captured beat is visible on vec the cycle after cap_en.
// Backpressure: none; every cap_en is written unconditionally.
module vec_beat_assembler
   import vmem_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cap_en,
   input  logic [BEAT_IDX_W-1:0]   cap_idx,
   input  logic [WORD_W-1:0]       cap_dat,
   output logic [WORD_W*BEATS-1:0] vec
);

   always_ff @(posedge clk) begin
      if (rst) begin
         vec <= '0;
      end else if (cap_en) begin
         vec[int'(cap_idx) * WORD_W +: WORD_W] <= cap_dat;
      end
   end

endmodule

// File: rtl/vec_mem_unit.sv
// Purpose: vector load/store between pipeline, single-port data memory and vector RF.
// Latency: store 5 cycles to done, load 5+READ_LAT cycles to writeback; busy stalls the pipe.
// Backpressure: start is only honoured in IDLE; VMEM_ALIGN_CHECK_EN adds a 16-byte alignment trap.
module vec_mem_unit
   import vmem_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int WORD_W    = 32,
   parameter int VEC_W     = 128,
   parameter int ADDR_STEP = 4,
   parameter int READ_LAT  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_load,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [4:0]        rd_in,
   input  logic [VEC_W-1:0]  store_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_re,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              wb_en,
   output logic [4:0]        wb_rd,
   output logic [VEC_W-1:0]  wb_data
);

   vmem_state_t             state_q, state_d;
   logic [ADDR_W-1:0]       base_q;
   logic [4:0]              rd_q;
   logic [VEC_W-1:0]        store_q;
   logic [VEC_W-1:0]        wb_hold_q;
   logic [VEC_W-1:0]        asm_vec;
   logic [BEAT_IDX_W-1:0]   beat_q;
   logic [1:0]              drain_q;
   logic [READ_LAT-1:0]     cap_vld_q;
   logic [BEAT_IDX_W-1:0]   cap_idx_q [READ_LAT];
   logic [ADDR_W-1:0]       beat_addr;
   logic                    misaligned;

`ifdef VMEM_ALIGN_CHECK_EN
   assign misaligned = |base_addr[3:0];
`else
   assign misaligned = 1'b0;
`endif

   // Address arithmetic wraps naturally at ADDR_W bits.
   assign beat_addr = base_q + (ADDR_W'(beat_q) * ADDR_W'(ADDR_STEP));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         rd_q      <= '0;
         store_q   <= '0;
         wb_hold_q <= '0;
         beat_q    <= '0;
         drain_q   <= '0;
         cap_vld_q <= '0;
         for (int i = 0; i < READ_LAT; i++) cap_idx_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && start) begin
            base_q  <= base_addr;
            rd_q    <= rd_in;
            store_q <= store_data;
         end
         // Four increments per transfer return the counter to zero for the next one.
         if (state_q == S_STORE || state_q == S_LOAD_ISSUE) beat_q <= beat_q + 1'b1;
         drain_q <= (state_q == S_LOAD_DRAIN) ? drain_q + 2'd1 : 2'd0;
         // Delay line pairs each read issue with its data arriving READ_LAT cycles later.
         cap_vld_q[0] <= (state_q == S_LOAD_ISSUE);
         cap_idx_q[0] <= beat_q;
         for (int i = 1; i < READ_LAT; i++) begin
            cap_vld_q[i] <= cap_vld_q[i-1];
            cap_idx_q[i] <= cap_idx_q[i-1];
         end
         if (state_q == S_WB) wb_hold_q <= asm_vec;
      end
   end

   vec_beat_assembler #(.WORD_W(WORD_W)) u_asm (
      .clk     (clk),
      .rst     (rst),
      .cap_en  (cap_vld_q[READ_LAT-1]),
      .cap_idx (cap_idx_q[READ_LAT-1]),
      .cap_dat (mem_rdata),
      .vec     (asm_vec)
   );

   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_wdata = '0;
      wb_en     = 1'b0;
      wb_rd     = '0;
      wb_data   = wb_hold_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (misaligned)   state_d = S_ERR;
               else if (is_load) state_d = S_LOAD_ISSUE;
               else              state_d = S_STORE;
            end
         end
         S_STORE: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = beat_addr;
            mem_wdata = beat_slice(store_q, beat_q);
            if (beat_q == LAST_BEAT) state_d = S_DONE;
         end
         S_LOAD_ISSUE: begin
            busy     = 1'b1;
            mem_re   = 1'b1;
            mem_addr = beat_addr;
            if (beat_q == LAST_BEAT) state_d = S_LOAD_DRAIN;
         end
         S_LOAD_DRAIN: begin
            busy = 1'b1;
            if (drain_q == 2'(READ_LAT - 1)) state_d = S_WB;
         end
         S_WB: begin
            busy    = 1'b1;
            done    = 1'b1;
            wb_en   = 1'b1;
            wb_rd   = rd_q;
            wb_data = asm_vec;
            state_d = S_IDLE;
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            busy    = 1'b1;
            done    = 1'b1;
            err     = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_vec_mem_unit.sv
// Directed bench: two instances (READ_LAT 1 and 3) share stimulus, each with its own memory.
module tb_vec_mem_unit;

   logic         clk = 1'b0;
   logic         rst, start, is_load;
   logic [31:0]  base_addr;
   logic [4:0]   rd_in;
   logic [127:0] store_data;

   logic         a_busy, a_done, a_err, a_mem_we, a_mem_re, a_wb_en;
   logic [31:0]  a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic [4:0]   a_wb_rd;
   logic [127:0] a_wb_data;
   logic         b_busy, b_done, b_err, b_mem_we, b_mem_re, b_wb_en;
   logic [31:0]  b_mem_addr, b_mem_wdata, b_mem_rdata;
   logic [4:0]   b_wb_rd;
   logic [127:0] b_wb_data;

   logic [31:0]  mem_a [256];
   logic [31:0]  mem_b [256];
   logic [31:0]  a_pipe;
   logic [31:0]  b_pipe [3];

   int n_chk = 0;
   int n_err = 0;
   int a_we_n = 0, a_re_n = 0, a_done_n = 0, a_wb_n = 0, a_err_n = 0;
   int b_we_n = 0, b_re_n = 0, b_done_n = 0, b_wb_n = 0;
   int s_a_we, s_a_done, s_a_wb, s_a_err, s_b_we, s_b_re, s_b_done, s_b_wb, s_a_re;

   localparam logic [127:0] VEC  = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] VEC2 = 128'hdddddddd_cccccccc_bbbbbbbb_aaaaaaaa;
   logic [127:0] vec_v;

   always #5 clk = ~clk;

   vec_mem_unit #(.READ_LAT(1)) dut_a (
      .clk(clk), .rst(rst), .start(start), .is_load(is_load), .base_addr(base_addr),
      .rd_in(rd_in), .store_data(store_data), .busy(a_busy), .done(a_done), .err(a_err),
      .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_re(a_mem_re), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .wb_en(a_wb_en), .wb_rd(a_wb_rd), .wb_data(a_wb_data)
   );

   vec_mem_unit #(.READ_LAT(3)) dut_b (
      .clk(clk), .rst(rst), .start(start), .is_load(is_load), .base_addr(base_addr),
      .rd_in(rd_in), .store_data(store_data), .busy(b_busy), .done(b_done), .err(b_err),
      .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_re(b_mem_re), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .wb_en(b_wb_en), .wb_rd(b_wb_rd), .wb_data(b_wb_data)
   );

   always @(posedge clk) begin
      if (a_mem_we) mem_a[a_mem_addr[9:2]] <= a_mem_wdata;
      a_pipe <= mem_a[a_mem_addr[9:2]];
      if (b_mem_we) mem_b[b_mem_addr[9:2]] <= b_mem_wdata;
      b_pipe[0] <= mem_b[b_mem_addr[9:2]];
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
   end
   assign a_mem_rdata = a_pipe;
   assign b_mem_rdata = b_pipe[2];

   always @(negedge clk) begin
      if (a_mem_we) a_we_n++;
      if (a_mem_re) a_re_n++;
      if (a_done)   a_done_n++;
      if (a_wb_en)  a_wb_n++;
      if (a_err)    a_err_n++;
      if (b_mem_we) b_we_n++;
      if (b_mem_re) b_re_n++;
      if (b_done)   b_done_n++;
      if (b_wb_en)  b_wb_n++;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s_a_we = a_we_n; s_a_re = a_re_n; s_a_done = a_done_n; s_a_wb = a_wb_n; s_a_err = a_err_n;
      s_b_we = b_we_n; s_b_re = b_re_n; s_b_done = b_done_n; s_b_wb = b_wb_n;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_load = 1'b0; base_addr = '0; rd_in = '0; store_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_busy", a_busy, 1'b0);
      chk("rst_done", a_done, 1'b0);
      chk("rst_err", a_err, 1'b0);
      chk("rst_we_re", {a_mem_we, a_mem_re, b_mem_we, b_mem_re}, 4'b0);
      chk("rst_addr", a_mem_addr, 32'h0);
      chk("rst_wb", {a_wb_en, b_wb_en, b_err}, 3'b0);
      chk("rst_wb_data", a_wb_data, 128'h0);
      @(negedge clk);

      // Store at 0x100, with a stray start at T+2 that must be ignored
      snap();
      base_addr = 32'h100; store_data = VEC; is_load = 1'b0; start = 1'b1;
      vec_v = VEC;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("st_we", a_mem_we, 1'b1);
         chk("st_re", a_mem_re, 1'b0);
         chk("st_addr", a_mem_addr, 32'h100 + 32'(4 * i));
         chk("st_wdata", a_mem_wdata, vec_v[32*i +: 32]);
         chk("st_busy", a_busy, 1'b1);
         chk("st_b_we", b_mem_we, 1'b1);
         if (i == 0) begin start = 1'b1; is_load = 1'b1; end
         else begin start = 1'b0; is_load = 1'b0; end
         @(negedge clk);
      end
      chk("st_done", a_done, 1'b1);
      chk("st_done_we", a_mem_we, 1'b0);
      chk("st_done_wdata", a_mem_wdata, 32'h0);
      chk("st_done_busy", a_busy, 1'b1);
      chk("st_b_done", b_done, 1'b1);
      @(negedge clk);
      chk("st_idle_busy", a_busy, 1'b0);
      chk("st_idle_done", a_done, 1'b0);
      repeat (2) @(negedge clk);
      chk("st_we_count", a_we_n - s_a_we, 4);
      chk("st_done_count", a_done_n - s_a_done, 1);
      chk("st_b_we_count", b_we_n - s_b_we, 4);
      chk("st_re_count", a_re_n - s_a_re, 0);
      chk("st_mem_word3", mem_a[8'h43], 32'h44444444);

      // Load back, rd 7; A has READ_LAT=1, B has READ_LAT=3
      snap();
      base_addr = 32'h100; rd_in = 5'd7; is_load = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("ld_re", a_mem_re, 1'b1);
         chk("ld_we", a_mem_we, 1'b0);
         chk("ld_addr", a_mem_addr, 32'h100 + 32'(4 * i));
         chk("ld_b_re", b_mem_re, 1'b1);
         @(negedge clk);
      end
      chk("ld_t5_re", a_mem_re, 1'b0);
      chk("ld_t5_wb", a_wb_en, 1'b0);
      chk("ld_t5_busy", a_busy, 1'b1);
      @(negedge clk);
      chk("ld_t6_wb", a_wb_en, 1'b1);
      chk("ld_t6_rd", a_wb_rd, 5'd7);
      chk("ld_t6_data", a_wb_data, VEC);
      chk("ld_t6_done", a_done, 1'b1);
      chk("ld_t6_busy", a_busy, 1'b1);
      chk("ld_t6_b_wb", b_wb_en, 1'b0);
      @(negedge clk);
      chk("ld_t7_busy", a_busy, 1'b0);
      chk("ld_t7_wb", a_wb_en, 1'b0);
      chk("ld_t7_hold", a_wb_data, VEC);
      chk("ld_t7_b_wb", b_wb_en, 1'b0);
      chk("ld_t7_b_busy", b_busy, 1'b1);
      @(negedge clk);
      chk("ld3_t8_wb", b_wb_en, 1'b1);
      chk("ld3_t8_rd", b_wb_rd, 5'd7);
      chk("ld3_t8_data", b_wb_data, VEC);
      chk("ld3_t8_done", b_done, 1'b1);
      @(negedge clk);
      chk("ld3_t9_busy", b_busy, 1'b0);
      repeat (2) @(negedge clk);
      chk("ld3_re_count", b_re_n - s_b_re, 4);
      chk("ld_wb_count", a_wb_n - s_a_wb, 1);
      chk("ld3_wb_count", b_wb_n - s_b_wb, 1);

      // Reset sampled at the end of T+3 of a load aborts it
      snap();
      base_addr = 32'h100; rd_in = 5'd9; is_load = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {a_busy, b_busy}, 2'b00);
      chk("abort_re", {a_mem_re, b_mem_re}, 2'b00);
      chk("abort_addr", a_mem_addr, 32'h0);
      chk("abort_wb_data", a_wb_data, 128'h0);
      repeat (8) @(negedge clk);
      chk("abort_no_wb", (a_wb_n - s_a_wb) + (b_wb_n - s_b_wb), 0);
      chk("abort_no_done", (a_done_n - s_a_done) + (b_done_n - s_b_done), 0);

      // Fresh load after the abort completes normally
      base_addr = 32'h100; rd_in = 5'd9; is_load = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("reld_wb", a_wb_en, 1'b1);
      chk("reld_rd", a_wb_rd, 5'd9);
      chk("reld_data", a_wb_data, VEC);
      repeat (2) @(negedge clk);
      chk("reld3_wb", b_wb_en, 1'b1);
      chk("reld3_data", b_wb_data, VEC);
      repeat (3) @(negedge clk);

      // Store to a base that is not 16-byte aligned
      snap();
      base_addr = 32'h104; store_data = VEC2; is_load = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
`ifdef VMEM_ALIGN_CHECK_EN
      chk("mis_err", a_err, 1'b1);
      chk("mis_done", a_done, 1'b1);
      chk("mis_busy", a_busy, 1'b1);
      chk("mis_we_re", {a_mem_we, a_mem_re}, 2'b00);
      @(negedge clk);
      chk("mis_idle", a_busy, 1'b0);
      repeat (6) @(negedge clk);
      chk("mis_we_count", a_we_n - s_a_we, 0);
      chk("mis_wb_count", a_wb_n - s_a_wb, 0);
      chk("mis_err_count", a_err_n - s_a_err, 1);
`else
      chk("mis_err", a_err, 1'b0);
      chk("mis_we", a_mem_we, 1'b1);
      chk("mis_addr", a_mem_addr, 32'h104);
      chk("mis_wdata", a_mem_wdata, 32'haaaaaaaa);
      repeat (4) @(negedge clk);
      chk("mis_done", a_done, 1'b1);
      repeat (3) @(negedge clk);
      chk("mis_we_count", a_we_n - s_a_we, 4);
      chk("mis_err_count", a_err_n - s_a_err, 0);
      chk("mis_mem_top", mem_a[8'h44], 32'hdddddddd);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/vec_mem_unit.md
Name: vec_mem_unit

Overview:
- Vector load/store stage between the pipeline, data memory, and the vector register file.
- Stores: a 128-bit vector (register file read port 2) is split into 32-bit beats and written to single-port data memory.
- Loads: 32-bit beats are read, assembled into a 128-bit vector, and presented as a one-cycle writeback (write enable, rd, data) to the vector register file.
- Stalls the pipeline while a transfer is in flight.

Parameters:
- ADDR_W, 32, data memory address width (byte addressing)
- WORD_W, 32, data memory word width
- VEC_W, 128, vector width; BEATS = VEC_W/WORD_W = 4
- ADDR_STEP, 4, address increment per beat
- READ_LAT, 1, cycles from read address to valid mem_rdata (1..3)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- is_load  in  1  1 = load, 0 = store
- base_addr  in  ADDR_W  vector base byte address
- rd_in  in  5  destination vector register (loads)
- store_data  in  VEC_W  vector to store
- busy  out  1  stall to pipeline
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle misalignment pulse
- mem_addr  out  ADDR_W  memory address
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_wdata  out  WORD_W  memory write data
- mem_rdata  in  WORD_W  memory read data
- wb_en  out  1  vector register file write enable
- wb_rd  out  5  vector register file write address
- wb_data  out  VEC_W  vector register file write data

Behaviour:
- Reset: state IDLE, all outputs 0, beat counters 0, assembly register 0.
- Reset mid-operation: abort immediately with no done and no wb_en. Beats already stored remain in memory.
- States: IDLE, STORE, LOAD_ISSUE, LOAD_DRAIN, WB, DONE, ERR.
- IDLE, start=1 at cycle T:
  - Register base_addr, rd_in, store_data, is_load.
  - Go to STORE or LOAD_ISSUE; busy=1 from T+1 until the cycle IDLE is re-entered.
- start while not IDLE is ignored.
- Beat i (0..3) covers bits [32i+31:32i] and uses mem_addr = base + i*ADDR_STEP, with modulo 2^ADDR_W wrap.
- STORE:
  - Cycles T+1..T+4: mem_we=1, mem_wdata = beat i.
  - T+5: DONE (done=1), then IDLE.
  - Store latency is 5 cycles.
- LOAD_ISSUE:
  - Cycles T+1..T+4: mem_re=1, one beat address per cycle.
  - mem_rdata is captured READ_LAT cycles after each issue, into slot i of the assembly register.
  - After the last issue, go to LOAD_DRAIN for READ_LAT cycles to capture the remaining data.
  - Then WB at T+5+READ_LAT: wb_en=1, wb_rd = latched rd, wb_data = assembled vector, done=1 in the same cycle.
  - Then IDLE.
- mem_we and mem_re are never both 1.
- mem_wdata is 0 when mem_we=0.
- wb_data holds its last value when wb_en=0.
- A start accepted in the same cycle as done/WB is impossible, because the FSM is not in IDLE that cycle.

Optional Feature:
- Macro: VMEM_ALIGN_CHECK_EN.
- Defined: start with base_addr[3:0] != 0 goes to ERR for one cycle.
  - err=1 and done=1; no memory access, no wb_en.
  - busy=1 that cycle, then IDLE.
- Undefined: no check, any address accepted, err tied to 0.

Decomposition:
- Package vmem_pkg holds:
  - state enum vmem_state_t;
  - BEATS;
  - BEAT_IDX_W = $clog2(BEATS);
  - function beat_slice(vec, idx).
- One sub-module, vec_beat_assembler: capture-enable + index to 128-bit register with per-slot write; clearable by rst.

Test Plan:
- Store: base 0x100, data 0x44444444_33333333_22222222_11111111 → writes 0x11111111@0x100, 0x22222222@0x104, 0x33333333@0x108, 0x44444444@0x10C on T+1..T+4; done at T+5.
- Load, READ_LAT=1: memory holds those words, rd_in=7 → wb_en=1 at T+6, wb_rd=7, wb_data equals the stored vector; busy high T+1..T+6.
- Load with READ_LAT=3: wb at T+8; no mem_re after T+4.
- start pulsed at T+2 during a store → ignored; exactly 4 writes and one done.
- rst asserted at T+3 of a load → outputs 0 next cycle, no wb_en, IDLE; a new load then completes normally.
- With VMEM_ALIGN_CHECK_EN, base 0x104 → err=done=1 at T+1, no mem_we/mem_re, no wb_en. Without the macro, the same request completes normally.
